fod_frac_div: RTL and testbench
===============================

FOD_FRAC_DIV -- requirements
Module: fod_frac_div

Interface
REQ-001 Parameter W_INT, default 8, width of the integer divide ratio.
REQ-002 Parameter W_FRAC, default 16, width of the fractional word and phase accumulator.
REQ-003 Port CK, input, 1: the single clock; all state updates on posedge CK.
REQ-004 Port RST, input, 1: reset, synchronous and active-high.
REQ-005 Port EN, input, 1: divider run enable.
REQ-006 Port DIV_INT, input, W_INT: integer divide ratio in CK cycles.
REQ-007 Port FRAC, input, W_FRAC: fractional increment, in units of 2^-W_FRAC half-CK-cycles per output period.
REQ-008 Port DIV_OUT, output, 1: divided pulse train, feeding D of the downstream pos/neg retimer.
REQ-009 Port POLARITY, output, 1: half-cycle select for the downstream retimer (1 = add 0.5 CK delay), feeding its POLARITY input.
REQ-010 Port BUSY, output, 1: high while a period is in progress (state not IDLE).

Function
REQ-011 The block SHALL implement FSM states IDLE, HIGH, LOW, with all outputs registered.
REQ-012 IDLE -> HIGH SHALL occur on the first posedge with EN=1; DIV_OUT rises one cycle after EN is sampled high.
REQ-013 Each period starts on the posedge entering HIGH ("start edge"). At that edge the block SHALL latch DIV_INT and FRAC into shadow registers; mid-period input changes take effect only at the next start edge.
REQ-014 Effective ratio N SHALL be max(DIV_INT, 2); values 0 and 1 are clamped to 2.
REQ-015 At each start edge: {c, acc} = acc + FRAC (W_FRAC+1 bits, carry c, wrap modulo 2^W_FRAC); p_new = p ^ c; period length L = N + (p & c), where p is the value before the update.
REQ-016 POLARITY SHALL be updated to p_new on the start edge, and SHALL remain stable until the next start edge, so that it is settled before the DIV_OUT falling edge.
REQ-017 DIV_OUT SHALL be high for H = max(1, L>>1) cycles (state HIGH) and low for L-H cycles (state LOW). A W_INT+1-bit down-counter SHALL time both phases.
REQ-018 At the end of LOW: if EN=1, the next edge SHALL be a start edge (HIGH) with no gap cycle; if EN=0, the next state SHALL be IDLE.
REQ-019 EN deassertion mid-period SHALL NOT truncate the period: the current HIGH/LOW completes, and no glitch occurs on DIV_OUT.
REQ-020 In IDLE: DIV_OUT=0, BUSY=0, and POLARITY, acc, p are held. Re-enabling SHALL resume the accumulator sequence.
REQ-021 Long-run average period SHALL equal N + FRAC/2^(W_FRAC+1) CK cycles, measured on retimer output edges.
REQ-022 FRAC=0 SHALL give an exact integer division with POLARITY constant.

Reset
REQ-023 On RST=1 at a posedge: state=IDLE, DIV_OUT=0, POLARITY=0, BUSY=0, acc=0, p=0, counter=0, shadow registers=0.
REQ-024 RST SHALL take priority over EN and any in-progress period, including mid-HIGH; DIV_OUT is low on the cycle after reset is sampled.
REQ-025 After RST falls with EN=1, the first start edge SHALL occur on the first posedge with RST=0.

Verification
REQ-026 DIV_INT=4, FRAC=0, EN=1 -> DIV_OUT period 4 (2 high, 2 low), POLARITY=0 throughout, BUSY=1.
REQ-027 DIV_INT=4, FRAC=0x8000 -> L sequence 4,4,4,5 repeating; POLARITY 0,1,1,0 per period; average edge spacing 4.25 cycles.
REQ-028 DIV_INT=1 (and 0), FRAC=0 -> period 2, 1 high / 1 low (clamped).
REQ-029 DIV_INT changed 4->6 during HIGH -> current period stays 4 cycles; next period is 6 (3 high, 3 low).
REQ-030 EN dropped in the 1st cycle of a 4-cycle period -> period completes; then DIV_OUT=0, BUSY=0; POLARITY is unchanged.
REQ-031 RST pulsed mid-HIGH with FRAC=0xFFFF -> next cycle all outputs 0, acc=0; after release, the first period follows from acc=0 (c=0, L=N).

Source files
------------

// File: rtl/fod_frac_div_if.sv
// fod_frac_div_if: control inputs and divided-clock outputs of the fractional divider.
// Ports: EN/DIV_INT/FRAC flow controller->divider; DIV_OUT/POLARITY/BUSY flow back.
// master = controller side, slave = divider side.
interface fod_frac_div_if #(
    parameter int W_INT  = 8,
    parameter int W_FRAC = 16
);
    logic              EN;
    logic [W_INT-1:0]  DIV_INT;
    logic [W_FRAC-1:0] FRAC;
    logic              DIV_OUT;
    logic              POLARITY;
    logic              BUSY;

    modport master (
        output EN, DIV_INT, FRAC,
        input  DIV_OUT, POLARITY, BUSY
    );

    modport slave (
        input  EN, DIV_INT, FRAC,
        output DIV_OUT, POLARITY, BUSY
    );
endinterface

// File: rtl/fod_frac_div.sv
// fod_frac_div: fractional clock divider producing a pulse train plus a half-cycle
// POLARITY select for a downstream pos/neg retimer (average period N + FRAC/2^(W_FRAC+1)).
// Ports: CK clock, RST sync active-high reset, bus (slave) carries EN/DIV_INT/FRAC in
// and DIV_OUT/POLARITY/BUSY out; all outputs registered, DIV_OUT rises 1 cycle after EN.
module fod_frac_div #(
    parameter int W_INT  = 8,
    parameter int W_FRAC = 16
) (
    input  logic           CK,
    input  logic           RST,
    fod_frac_div_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t            state;
    logic [W_INT:0]    cnt;       // remaining cycles of the current phase
    logic [W_FRAC-1:0] acc;       // phase accumulator
    logic              p;         // half-cycle phase, drives POLARITY directly
    logic              div_out;
    logic              busy;
    logic [W_INT-1:0]  sh_int;    // DIV_INT captured at the start edge
    logic              ext;       // extra cycle (p & carry) captured at the start edge

    logic [W_FRAC:0]   sum;
    logic              carry;
    logic [W_INT:0]    l_new;     // length of the period starting on this edge
    logic [W_INT:0]    l_cur;     // length of the period in progress
    logic              start;

    localparam logic [W_INT:0] ONE = (W_INT+1)'(1);

    // L = max(DIV_INT, 2) + extra; fits W_INT+1 bits even at DIV_INT all-ones.
    function automatic logic [W_INT:0] period_len(input logic [W_INT-1:0] d, input logic e);
        logic [W_INT:0] n;
        n = (d < W_INT'(2)) ? (W_INT+1)'(2) : {1'b0, d};
        return n + {{W_INT{1'b0}}, e};
    endfunction

    always_comb begin
        sum   = {1'b0, acc} + {1'b0, bus.FRAC};
        carry = sum[W_FRAC];
        l_new = period_len(bus.DIV_INT, p & carry);
        l_cur = period_len(sh_int, ext);
        // A new period begins from IDLE, or back-to-back at the last LOW cycle.
        start = bus.EN && ((state == IDLE) || ((state == LOW) && (cnt == ONE)));
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            p       <= 1'b0;
            div_out <= 1'b0;
            busy    <= 1'b0;
            sh_int  <= '0;
            ext     <= 1'b0;
        end else if (start) begin
            // FRAC acts only here, so its effect is fully captured in acc/p/ext;
            // DIV_INT is kept in sh_int to time the LOW phase of this period.
            state   <= HIGH;
            cnt     <= l_new >> 1;   // L >= 2, so the high time is always >= 1
            div_out <= 1'b1;
            busy    <= 1'b1;
            acc     <= sum[W_FRAC-1:0];
            p       <= p ^ carry;
            sh_int  <= bus.DIV_INT;
            ext     <= p & carry;
        end else begin
            case (state)
                HIGH: begin
                    if (cnt == ONE) begin
                        state   <= LOW;
                        cnt     <= l_cur - (l_cur >> 1);
                        div_out <= 1'b0;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                LOW: begin
                    if (cnt == ONE) begin
                        // EN low here (start would otherwise have fired): stop cleanly.
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                IDLE: begin
                    div_out <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    div_out <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.DIV_OUT  = div_out;
    assign bus.POLARITY = p;
    assign bus.BUSY     = busy;
endmodule

// File: tb/tb_fod_frac_div.sv
// tb_fod_frac_div: directed bench for fod_frac_div with hand-computed period/polarity values.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
// Summary line reports comparisons made and failures seen.
module tb_fod_frac_div;
    logic ck;
    logic rst;
    int   n_checks;
    int   n_fail;

    fod_frac_div_if #(.W_INT(8), .W_FRAC(16)) bus ();

    fod_frac_div #(.W_INT(8), .W_FRAC(16)) dut (
        .CK  (ck),
        .RST (rst),
        .bus (bus)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Called at a falling edge; counts falling edges until DIV_OUT reads 1.
    task automatic wait_high(output int n);
        n = 0;
        while (bus.DIV_OUT !== 1'b1 && n < 50) begin
            @(negedge ck);
            n++;
        end
    endtask

    // Called at the first high sample of a period; returns at the first high
    // sample of the next period.
    task automatic measure(output int hi, output int lo, output logic pol, output logic bsy);
        pol = bus.POLARITY;
        bsy = bus.BUSY;
        hi = 0;
        while (bus.DIV_OUT === 1'b1 && hi < 600) begin
            hi++;
            @(negedge ck);
        end
        lo = 0;
        while (bus.DIV_OUT === 1'b0 && lo < 600) begin
            lo++;
            @(negedge ck);
        end
    endtask

    int   hi, lo, n, total;
    logic pol, bsy;

    // FRAC=0x8000 from acc=0,p=0: L 4,4,4,5 ; POLARITY 0,1,1,0
    int   exp_hi27 [4] = '{2, 2, 2, 2};
    int   exp_lo27 [4] = '{2, 2, 2, 3};
    logic exp_pol27[4] = '{1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.EN = 1'b0;
        bus.DIV_INT = 8'd4;
        bus.FRAC = 16'd0;
        repeat (3) @(posedge ck);
        @(negedge ck);
        check("rst_div_out", 32'(bus.DIV_OUT), 0);
        check("rst_pol", 32'(bus.POLARITY), 0);
        check("rst_busy", 32'(bus.BUSY), 0);

        // Integer divide by 4
        rst = 1'b0;
        bus.EN = 1'b1;
        wait_high(n);
        check("first_rise_latency", n, 1);
        for (int i = 0; i < 3; i++) begin
            measure(hi, lo, pol, bsy);
            check("div4_hi", hi, 2);
            check("div4_lo", lo, 2);
            check("div4_pol", 32'(pol), 0);
            check("div4_busy", 32'(bsy), 1);
        end

        // FRAC=0x8000: current (already latched) period still L=4
        bus.FRAC = 16'h8000;
        measure(hi, lo, pol, bsy);
        check("frac_switch_len", hi + lo, 4);
        total = 0;
        for (int i = 0; i < 4; i++) begin
            measure(hi, lo, pol, bsy);
            check("frac_hi", hi, exp_hi27[i]);
            check("frac_lo", lo, exp_lo27[i]);
            check("frac_pol", 32'(pol), 32'(exp_pol27[i]));
            total += hi + lo;
        end
        check("frac_total_4_periods", total, 17);

        // Clamp: DIV_INT=1 then 0 with FRAC=0 (current period: acc 0x8000, L=4)
        bus.FRAC = 16'd0;
        bus.DIV_INT = 8'd1;
        measure(hi, lo, pol, bsy);
        check("clamp_transition_len", hi + lo, 4);
        for (int i = 0; i < 2; i++) begin
            measure(hi, lo, pol, bsy);
            check("clamp1_hi", hi, 1);
            check("clamp1_lo", lo, 1);
        end
        bus.DIV_INT = 8'd0;
        measure(hi, lo, pol, bsy);
        for (int i = 0; i < 2; i++) begin
            measure(hi, lo, pol, bsy);
            check("clamp0_hi", hi, 1);
            check("clamp0_lo", lo, 1);
        end

        // DIV_INT 4 -> 6 during HIGH
        bus.DIV_INT = 8'd4;
        measure(hi, lo, pol, bsy);
        bus.DIV_INT = 8'd6;
        measure(hi, lo, pol, bsy);
        check("midhigh_cur_hi", hi, 2);
        check("midhigh_cur_lo", lo, 2);
        measure(hi, lo, pol, bsy);
        check("div6_hi", hi, 3);
        check("div6_lo", lo, 3);

        // Next period: acc 0x8000 -> carry, p 0->1, L=4
        bus.DIV_INT = 8'd4;
        bus.FRAC = 16'h8000;
        measure(hi, lo, pol, bsy);
        check("pre_stop_pol", 32'(bus.POLARITY), 1);
        bus.EN = 1'b0;
        hi = 0;
        while (bus.DIV_OUT === 1'b1 && hi < 50) begin
            hi++;
            @(negedge ck);
        end
        check("stop_hi_not_truncated", hi, 2);
        lo = 0;
        while (bus.DIV_OUT === 1'b0 && lo < 20) begin
            lo++;
            @(negedge ck);
        end
        check("stop_stays_low", lo, 20);
        check("stop_busy", 32'(bus.BUSY), 0);
        check("stop_pol_held", 32'(bus.POLARITY), 1);

        // Re-enable resumes acc=0,p=1: L=4 pol 1, then L=5 pol 0
        bus.EN = 1'b1;
        wait_high(n);
        check("resume_latency", n, 1);
        measure(hi, lo, pol, bsy);
        check("resume1_len", hi + lo, 4);
        check("resume1_pol", 32'(pol), 1);
        measure(hi, lo, pol, bsy);
        check("resume2_hi", hi, 2);
        check("resume2_lo", lo, 3);
        check("resume2_pol", 32'(pol), 0);

        // Reset mid-HIGH with FRAC=0xFFFF
        bus.FRAC = 16'hFFFF;
        check("pre_rst_high", 32'(bus.DIV_OUT), 1);
        rst = 1'b1;
        @(negedge ck);
        check("midrst_div_out", 32'(bus.DIV_OUT), 0);
        check("midrst_pol", 32'(bus.POLARITY), 0);
        check("midrst_busy", 32'(bus.BUSY), 0);
        rst = 1'b0;
        wait_high(n);
        check("post_rst_latency", n, 1);
        measure(hi, lo, pol, bsy);
        check("post_rst1_len", hi + lo, 4);
        check("post_rst1_pol", 32'(pol), 0);
        measure(hi, lo, pol, bsy);
        check("post_rst2_len", hi + lo, 4);
        check("post_rst2_pol", 32'(pol), 1);
        measure(hi, lo, pol, bsy);
        check("post_rst3_len", hi + lo, 5);
        check("post_rst3_pol", 32'(pol), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
